// File: rtl/down_counter_timer.sv
// Loadable, enable-gated down-counter with terminal-count pulse and optional
// auto-reload. The count reloads from rld on the terminal step in periodic mode.
module down_counter_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic             mode,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q, rld_q;
  logic             tc_q, busy_q;
  logic             term_d;

  // Terminal step: the enabled RUN cycle that sees a count of one.
  assign term_d = (state_q == RUN) && enab && (cnt_q == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (load) begin
      cnt_q <= cnt_in;
      rld_q <= cnt_in;
      tc_q  <= 1'b0;
      if (cnt_in != '0) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end else begin
      tc_q <= term_d;
      case (state_q)
        RUN: begin
          if (term_d) begin
            if (mode) begin
              cnt_q <= rld_q;
            end else begin
              cnt_q   <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end else if (enab && cnt_q > WIDTH'(1)) begin
            cnt_q <= cnt_q - WIDTH'(1);
          end
        end
        IDLE, DONE: ;
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_out = cnt_q;
  assign tc      = tc_q;
  assign busy    = busy_q;

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable, enable-gated down-counter with terminal-count detection and optional auto-reload. It is the decrementing counterpart of the team's loadable up-counter: software or a control FSM loads a period, then the block counts down on enabled cycles and reports expiry. It provides one-shot delays and periodic ticks to pipeline and control logic in the core.

## Interface
- WIDTH, 5, width of the count, load value and reload register.

- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- load  input  1  load cnt_in into both the counter and the reload register.
- enab  input  1  count enable. Decrements only while in RUN.
- mode  input  1  0 = one-shot, 1 = periodic (auto-reload).
- cnt_in  input  WIDTH  load value, i.e. the period.
- cnt_out  output  WIDTH  current count. Registered.
- tc  output  1  terminal-count pulse. Registered, one cycle wide.
- busy  output  1  high while in RUN. Registered.

## Operation
- Internal state: reload register `rld` (WIDTH bits) and a 3-state FSM.
  - IDLE: not loaded, or loaded with 0.
  - RUN: counting.
  - DONE: one-shot has expired.
- Per-cycle priority is rst > load > enab > hold.
- On rst:
  - cnt_out=0, rld=0, tc=0, busy=0, state=IDLE.
- On load, from any state:
  - cnt_out<=cnt_in, rld<=cnt_in, tc<=0.
  - If cnt_in≠0, state<=RUN and busy<=1.
  - If cnt_in==0, state<=IDLE and busy<=0.
- In RUN with enab=1 and cnt_out>1:
  - cnt_out<=cnt_out−1, tc<=0.
- In RUN with enab=1 and cnt_out==1 (the terminal step), mode is sampled in this cycle:
  - mode=0: cnt_out<=0, tc<=1, state<=DONE, busy<=0.
  - mode=1: cnt_out<=rld, tc<=1, state stays RUN. The count never shows 0.
- In RUN with enab=0: cnt_out holds, tc<=0.
- In IDLE or DONE: enab is ignored, cnt_out holds, tc<=0. Only load leaves these states.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The counter never decrements below 0 and never wraps to all-ones.
  - Maximum period is 2^WIDTH−1.
- A mode change in RUN takes effect only at the next terminal step. It has no effect on the current count.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Load latency is 1 cycle: cnt_out equals cnt_in in the cycle after load is sampled high.
- Period: a load of N≥1 followed by continuous enab gives:
  - one-shot: cnt_out = N, N−1, …, 1, 0 over N+1 cycles; tc is high in the cycle cnt_out first shows 0.
  - periodic: tc is high every N enabled cycles, coincident with cnt_out showing N again.
- Stalling enab stretches the period cycle-for-cycle. The count resumes exactly where it stopped.
- Boundary cases:
  - Load of 1, periodic: cnt_out stays 1 and tc is high on every enabled cycle.
  - Load of 1, one-shot: the next enabled cycle gives cnt_out=0 and tc=1.
  - Load and terminal step in the same cycle: load wins and tc stays 0.
  - rst during RUN: takes effect next edge; tc, busy and cnt_out all go 0.
  - Load of 0: no tc, busy=0, and enab has no effect.
  - rst and load in the same cycle: rst wins.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> cnt_out=0, tc=0, busy=0; enab=1 afterwards without a load leaves cnt_out at 0 and tc at 0.
- One-shot: load 5, mode=0, enab=1 held -> cnt_out 5,4,3,2,1,0; tc=1 only in the cycle showing 0; busy falls in that same cycle; cnt_out stays 0 afterwards.
- Periodic with stall: load 3, mode=1, enab toggled 1,1,0,0,1 and then held -> cnt_out 3,2,1 (held 2 cycles),3,2,1,3…; tc high exactly when cnt_out returns to 3.
- Collision: periodic count at cnt_out=1, then load=1 with cnt_in=7 and enab=1 in the same cycle -> cnt_out=7, tc=0; rld=7, so the next period is 7.
- Edge loads:
  - load 0 -> busy=0, tc never fires.
  - load 1 periodic -> tc=1 every enabled cycle.
  - load 31 at WIDTH=5 -> first tc after 31 enabled cycles.
- Mid-run control: rst asserted at cnt_out=4 -> next cycle all outputs 0, state IDLE; mode switched 1->0 at cnt_out=2 -> the run ends in DONE with a single tc.
